// File: rtl/payload_engine_ctrl_pkg.sv
// Shared types and default sizing for the payload engine controller and its
// report register.
package payload_engine_ctrl_pkg;

  localparam int NUM_ENGINES_DEF  = 16;
  localparam int DRAIN_CYCLES_DEF = 2;
  localparam int LEN_W_DEF        = 16;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SCAN,
    DRAIN,
    REPORT
  } state_t;

endpackage

// File: rtl/payload_report_reg.sv
// Holds one match report and keeps it stable until the consumer accepts it.
module payload_report_reg
  import payload_engine_ctrl_pkg::*;
#(
  parameter int NUM_ENGINES = NUM_ENGINES_DEF,
  parameter int LEN_W       = LEN_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   capture_i,
  input  logic [NUM_ENGINES-1:0] match_i,
  input  logic [LEN_W-1:0]       len_i,
  input  logic                   m_ready_i,
  output logic                   m_valid_o,
  output logic [NUM_ENGINES-1:0] m_match_o,
  output logic                   m_any_o,
  output logic [LEN_W-1:0]       m_len_o
);

  logic                   valid_q, valid_d;
  logic [NUM_ENGINES-1:0] match_q, match_d;
  logic                   any_q, any_d;
  logic [LEN_W-1:0]       len_q, len_d;

  always_comb begin
    valid_d = valid_q;
    match_d = match_q;
    any_d   = any_q;
    len_d   = len_q;
    if (capture_i) begin
      valid_d = 1'b1;
      match_d = match_i;
      any_d   = |match_i;
      len_d   = len_i;
    end else if (valid_q && m_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      match_q <= '0;
      any_q   <= 1'b0;
      len_q   <= '0;
    end else begin
      valid_q <= valid_d;
      match_q <= match_d;
      any_q   <= any_d;
      len_q   <= len_d;
    end
  end

  assign m_valid_o = valid_q;
  assign m_match_o = match_q;
  assign m_any_o   = any_q;
  assign m_len_o   = len_q;

endmodule

// File: rtl/payload_engine_ctrl.sv
// Sequences a bank of payload-matching engines: per-packet clear, byte strobes,
// pipeline drain, then one masked match report per packet.
module payload_engine_ctrl
  import payload_engine_ctrl_pkg::*;
#(
  parameter int NUM_ENGINES  = NUM_ENGINES_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int LEN_W        = LEN_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [7:0]             s_data,
  input  logic                   s_sop,
  input  logic                   s_eop,
  input  logic [NUM_ENGINES-1:0] cfg_mask,
  output logic                   eng_sod,
  output logic                   eng_en,
  output logic [7:0]             eng_byte,
  input  logic [NUM_ENGINES-1:0] eng_match,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [NUM_ENGINES-1:0] m_match,
  output logic                   m_any,
  output logic [LEN_W-1:0]       m_len,
  output logic                   err_stray
);

  localparam int DW = $clog2(DRAIN_CYCLES + 2);

  state_t                 state_q, state_d;
  logic [NUM_ENGINES-1:0] mask_q, mask_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [DW-1:0]          drain_q, drain_d;
  logic                   eng_sod_q, eng_sod_d;
  logic                   eng_en_q, eng_en_d;
  byte_t                  eng_byte_q, eng_byte_d;
  logic                   err_stray_q, err_stray_d;
  logic                   ready_c;
  logic                   capture;

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    len_d       = len_q;
    drain_d     = drain_q;
    eng_sod_d   = 1'b0;
    eng_en_d    = 1'b0;
    eng_byte_d  = eng_byte_q;
    err_stray_d = 1'b0;
    ready_c     = 1'b0;
    capture     = 1'b0;
    case (state_q)
      IDLE: begin
        // Stray mid-packet bytes are swallowed; an SOP waits for the clear.
        ready_c     = s_valid & ~s_sop;
        err_stray_d = s_valid & ~s_sop;
        if (s_valid && s_sop) state_d = CLEAR;
      end
      CLEAR: begin
        eng_sod_d = 1'b1;
        mask_d    = cfg_mask;
        len_d     = '0;
        state_d   = SCAN;
      end
      SCAN: begin
        ready_c = 1'b1;
        if (s_valid) begin
          eng_en_d   = 1'b1;
          eng_byte_d = s_data;
          if (len_q != '1) len_d = len_q + LEN_W'(1);
          if (s_eop) begin
            state_d = DRAIN;
            drain_d = DW'(DRAIN_CYCLES);
          end
        end
      end
      DRAIN: begin
        // Wait for the decode stage and engine end-state register to settle.
        if (drain_q == '0) begin
          capture = 1'b1;
          state_d = REPORT;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      REPORT: begin
        if (m_valid && m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      len_q       <= '0;
      drain_q     <= '0;
      eng_sod_q   <= 1'b1;
      eng_en_q    <= 1'b0;
      eng_byte_q  <= '0;
      err_stray_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      len_q       <= len_d;
      drain_q     <= drain_d;
      eng_sod_q   <= eng_sod_d;
      eng_en_q    <= eng_en_d;
      eng_byte_q  <= eng_byte_d;
      err_stray_q <= err_stray_d;
    end
  end

  // No byte is taken while reset is asserted, whatever state is held.
  assign s_ready   = rst_n & ready_c;
  assign eng_sod   = eng_sod_q;
  assign eng_en    = eng_en_q;
  assign eng_byte  = eng_byte_q;
  assign err_stray = err_stray_q;

  payload_report_reg #(
    .NUM_ENGINES(NUM_ENGINES),
    .LEN_W      (LEN_W)
  ) u_report (
    .clk      (clk),
    .rst_n    (rst_n),
    .capture_i(capture),
    .match_i  (eng_match & mask_q),
    .len_i    (len_q),
    .m_ready_i(m_ready),
    .m_valid_o(m_valid),
    .m_match_o(m_match),
    .m_any_o  (m_any),
    .m_len_o  (m_len)
  );

endmodule

// File: tb/tb_payload_engine_ctrl.sv
// Scoreboard bench: stimulus queues expected engine bytes and reports,
// negedge monitors pop and compare them as the DUT presents them.
module tb_payload_engine_ctrl;

  localparam int NE = 16;
  localparam int LW = 16;

  typedef struct packed {
    logic [NE-1:0] match;
    logic          any;
    logic [LW-1:0] len;
  } rep_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [7:0]    s_data;
  logic          s_sop;
  logic          s_eop;
  logic [NE-1:0] cfg_mask;
  logic          eng_sod;
  logic          eng_en;
  logic [7:0]    eng_byte;
  logic [NE-1:0] eng_match;
  logic          m_valid;
  logic          m_ready;
  logic [NE-1:0] m_match;
  logic          m_any;
  logic [LW-1:0] m_len;
  logic          err_stray;

  int tests = 0;
  int fails = 0;

  rep_t       exp_q[$];
  logic [7:0] byte_q[$];
  logic       prev_sod = 1'b0;
  logic       sod_armed = 1'b0;

  always #5 clk = ~clk;

  payload_engine_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_sop    (s_sop),
    .s_eop    (s_eop),
    .cfg_mask (cfg_mask),
    .eng_sod  (eng_sod),
    .eng_en   (eng_en),
    .eng_byte (eng_byte),
    .eng_match(eng_match),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_match  (m_match),
    .m_any    (m_any),
    .m_len    (m_len),
    .err_stray(err_stray)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Engine-side monitor: byte strobes, strobe/clear ordering.
  always @(negedge clk) begin
    if (eng_sod === 1'b1) sod_armed = 1'b1;
    if (eng_en === 1'b1) begin
      check("en_sod_overlap", {31'd0, eng_sod}, 32'd0);
      if (sod_armed) begin
        check("sod_one_before_en", {31'd0, prev_sod}, 32'd1);
        sod_armed = 1'b0;
      end
      if (byte_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_eng_en: got byte %02h, expected no strobe", eng_byte);
      end else begin
        check("eng_byte", {24'd0, eng_byte}, {24'd0, byte_q.pop_front()});
      end
    end
    prev_sod = eng_sod;
  end

  // Report monitor: compares every accepted report against the scoreboard.
  always @(negedge clk) begin
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      $display("[TB] report match=%04h any=%0d len=%0d", m_match, m_any, m_len);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_report: got len %0d, expected no report", m_len);
      end else begin
        rep_t e;
        e = exp_q.pop_front();
        check("m_match", {16'd0, m_match}, {16'd0, e.match});
        check("m_any", {31'd0, m_any}, {31'd0, e.any});
        check("m_len", {16'd0, m_len}, {16'd0, e.len});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] d, input logic sop, input logic eop);
    bit done;
    done    = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_sop   = sop;
    s_eop   = eop;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (s_ready) begin
        byte_q.push_back(d);
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    s_valid = 1'b0;
    s_sop   = 1'b0;
    s_eop   = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: byte %02h not accepted, expected s_ready", d);
    end
  endtask

  // Returns cycles from the EOP accept edge until m_valid is seen.
  task automatic wait_report(output int lat);
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m_valid) return;
      lat++;
    end
    tests++;
    fails++;
    $display("FAIL report_timeout: m_valid=0 after %0d cycles, expected 1", lat);
  endtask

  initial begin
    int lat;
    rst_n     = 1'b0;
    s_valid   = 1'b1;
    s_sop     = 1'b0;
    s_eop     = 1'b0;
    s_data    = 8'h55;
    cfg_mask  = 16'hFFFF;
    eng_match = 16'h0004;
    m_ready   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {23'd0, eng_sod, eng_en, s_ready, m_valid, m_any, err_stray, 3'd0},
          {23'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0});
    check("reset_eng_byte", {24'd0, eng_byte}, 32'd0);
    check("reset_m_match", {16'd0, m_match}, 32'd0);
    check("reset_m_len", {16'd0, m_len}, 32'd0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;

    // ".de" with all engines reported.
    send_byte(8'h2E, 1'b1, 1'b0);
    send_byte(8'h64, 1'b0, 1'b0);
    send_byte(8'h65, 1'b0, 1'b1);
    exp_q.push_back('{match: 16'h0004, any: 1'b1, len: 16'd3});
    wait_report(lat);
    check("latency_pkt1", lat, 32'd3);

    // Same packet, matching engine masked off.
    cfg_mask = 16'hFFFB;
    send_byte(8'h2E, 1'b1, 1'b0);
    send_byte(8'h64, 1'b0, 1'b0);
    send_byte(8'h65, 1'b0, 1'b1);
    exp_q.push_back('{match: 16'h0000, any: 1'b0, len: 16'd3});
    wait_report(lat);
    check("latency_pkt2", lat, 32'd3);
    @(posedge clk);
    #1;

    // One-byte packet with back-pressure; a stray byte waits behind it.
    m_ready  = 1'b0;
    cfg_mask = 16'hFFFF;
    send_byte(8'h28, 1'b1, 1'b1);
    exp_q.push_back('{match: 16'h0004, any: 1'b1, len: 16'd1});
    s_valid = 1'b1;
    s_data  = 8'h41;
    s_sop   = 1'b0;
    wait_report(lat);
    check("latency_pkt3", lat, 32'd3);
    for (int i = 0; i < 5; i++) begin
      check("hold_s_ready", {31'd0, s_ready}, 32'd0);
      check("hold_report", {m_valid, m_any, m_match, m_len[13:0]}, {1'b1, 1'b1, 16'h0004, 14'd1});
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        if (s_ready) got = 1'b1;
      end
      check("stray_accepted", {31'd0, got}, 32'd1);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    @(negedge clk);
    check("err_stray_pulse", {31'd0, err_stray}, 32'd1);
    @(negedge clk);
    check("err_stray_single", {31'd0, err_stray}, 32'd0);
    check("stray_no_report", {31'd0, m_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Gaps between beats: strobes only on accepted bytes.
    send_byte(8'h11, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    send_byte(8'h22, 1'b0, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    send_byte(8'h33, 1'b0, 1'b1);
    exp_q.push_back('{match: 16'h0004, any: 1'b1, len: 16'd3});
    wait_report(lat);
    check("latency_gaps", lat, 32'd3);
    @(posedge clk);
    #1;

    // Reset in the middle of a packet discards it.
    send_byte(8'hA0, 1'b1, 1'b0);
    send_byte(8'hA1, 1'b0, 1'b0);
    send_byte(8'hA2, 1'b0, 1'b0);
    send_byte(8'hA3, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_eng_sod", {31'd0, eng_sod}, 32'd1);
    check("midrst_eng_en", {31'd0, eng_en}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("midrst_no_report", {31'd0, m_valid}, 32'd0);
      @(negedge clk);
    end

    // Mask is latched at the clear; changing it mid-packet has no effect.
    cfg_mask  = 16'h00FF;
    eng_match = 16'h0104;
    send_byte(8'hB0, 1'b1, 1'b0);
    cfg_mask = 16'hFFFF;
    send_byte(8'hB1, 1'b0, 1'b1);
    exp_q.push_back('{match: 16'h0004, any: 1'b1, len: 16'd2});
    wait_report(lat);
    check("latency_post_rst", lat, 32'd3);

    repeat (5) @(negedge clk);
    check("reports_drained", exp_q.size(), 32'd0);
    check("bytes_drained", byte_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
